fifo_sync: RTL and testbench
============================

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, log2 of depth; DEPTH = 2^ADDR_WIDTH entries, all usable.
REQ-002 Parameter DATA_WIDTH, default 8, word width.
REQ-003 Parameter MODE, default 1, 0 = standard read, 1 = first-word-fall-through (FWFT).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 resetb  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of contents.
REQ-007 we  input  1  write request; wdata  input  DATA_WIDTH  write data.
REQ-008 re  input  1  read/pop request; rdata  output  DATA_WIDTH  read data.
REQ-009 full  output  1; empty  output  1.
REQ-010 used  output  ADDR_WIDTH+1  words held; free  output  ADDR_WIDTH+1  DEPTH minus used.
REQ-011 afull_thresh, aempty_thresh  input  ADDR_WIDTH+1  level thresholds; almost_full, almost_empty  output  1.
REQ-012 overflow, underflow  output  1  sticky error flags.

Function
REQ-013 Accepted write = we & !full; accepted read = re & !empty; full/empty sampled before the edge.
REQ-014 used: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither; registered.
REQ-015 full = (used == DEPTH); almost_full = (used >= afull_thresh); almost_empty = (used <= aempty_thresh); combinational from registered used.
REQ-016 Write and read pointers are ADDR_WIDTH bits and wrap modulo DEPTH with no gap entry.
REQ-017 MODE 0: empty = (used == 0); rdata updates one cycle after an accepted read and holds until the next accepted read.
REQ-018 MODE 1: an output register holds the head word; empty = !head_valid; rdata valid whenever empty is low; re pops the head.
REQ-019 MODE 1: a write into a fully empty FIFO at edge N makes empty fall after edge N+2; used reads 1 after edge N.
REQ-020 MODE 1: back-to-back pops at one per cycle with no bubble while used >= 2; used includes the head word.
REQ-021 Write while full: write dropped, contents untouched, overflow set; simultaneous read still accepted.
REQ-022 Read while empty: no pointer change, rdata unchanged, underflow set; simultaneous write still accepted.
REQ-023 flush has priority over we/re in the same cycle; after the edge: pointers 0, used 0, empty 1, full 0, head invalid, overflow/underflow 0.
REQ-024 Threshold inputs are quasi-static; changes take effect combinationally.

Reset
REQ-025 resetb low asynchronously forces: pointers 0, used 0, free DEPTH, full 0, empty 1, head_valid 0, overflow 0, underflow 0.
REQ-026 rdata resets to 0 in MODE 1; in MODE 0 rdata is don't-care until the first accepted read.
REQ-027 Reset deassertion is synchronised externally; first accepted write is allowed on the first edge after release.

Configuration
REQ-028 Macro FIFO_SYNC_ERRFLAG_EN defined: overflow/underflow are implemented per REQ-021/022/023.
REQ-029 Macro FIFO_SYNC_ERRFLAG_EN undefined: overflow and underflow are tied 0; drop/ignore protection stays active.

Structure
REQ-030 Shared package fifo_pkg holds MODE encodings FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
REQ-031 Storage is the existing fifo_ram sub-module with clka = clkb = clk and a registered read port of one cycle latency.
REQ-032 Pointer, count and FWFT prefetch logic live in fifo_sync; no further sub-modules.

Verification
REQ-033 ADDR_WIDTH=4, MODE 1: write 0x01..0x10 -> full=1, used=16, free=0 after 16th write; 17th write 0xAA -> dropped, overflow=1.
REQ-034 MODE 1: single write 0x5A into empty FIFO at edge N -> used=1 after N, empty=0 and rdata=0x5A after N+2.
REQ-035 MODE 0, 3 words in FIFO: pulse re once -> rdata = first word one cycle later, used=2.
REQ-036 Full FIFO, we=re=1 for one cycle -> write dropped, read accepted, used=15, overflow=1.
REQ-037 afull_thresh=12, aempty_thresh=2: fill to 12 -> almost_full rises exactly at used=12; drain to 2 -> almost_empty rises.
REQ-038 Fill 9 words, assert flush with we=1 -> next cycle used=0, empty=1, flags 0; 20 write/read wraps then return the data in order.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode encodings used by fifo_sync's MODE parameter.
package fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // True when the mode value selects first-word-fall-through behaviour.
    function automatic bit fifo_is_fwft(input int unsigned mode);
        return mode == FIFO_MODE_FWFT;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port (1-cycle latency).
module fifo_ram #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clka,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  clkb,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clka) begin
        if (wea) begin
            mem[addra] <= dina;
        end
    end

    // Output register holds its value while enb is low.
    always_ff @(posedge clkb) begin
        if (enb) begin
            doutb <= mem[addrb];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with standard or first-word-fall-through read, level thresholds,
// and optional sticky overflow/underflow flags (define FIFO_SYNC_ERRFLAG_EN).
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MODE       = FIFO_MODE_FWFT
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  flush,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   used,
    output logic [ADDR_WIDTH:0]   free,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CW-1:0]         used_q;
    logic [CW-1:0]         used_d;
    logic                  wr_acc_c;
    logic                  rd_acc_c;
    logic                  ram_rd_c;
    logic [DATA_WIDTH-1:0] ram_q;

    // Flush wins over both requests; full/empty are the pre-edge values.
    assign wr_acc_c = we & ~full & ~flush;
    assign rd_acc_c = re & ~empty & ~flush;

    assign full         = (used_q == DEPTH_C);
    assign used         = used_q;
    assign free         = DEPTH_C - used_q;
    assign almost_full  = (used_q >= afull_thresh);
    assign almost_empty = (used_q <= aempty_thresh);

    fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clka  (clk),
        .wea   (wr_acc_c),
        .addra (wptr),
        .dina  (wdata),
        .clkb  (clk),
        .enb   (ram_rd_c),
        .addrb (rptr),
        .doutb (ram_q)
    );

    always_comb begin
        used_d = used_q;
        if (wr_acc_c && !rd_acc_c) begin
            used_d = used_q + CW'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            used_d = used_q - CW'(1);
        end
    end

    // Pointers wrap naturally at DEPTH; the count disambiguates full from empty.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wptr   <= '0;
            rptr   <= '0;
            used_q <= '0;
        end else if (flush) begin
            wptr   <= '0;
            rptr   <= '0;
            used_q <= '0;
        end else begin
            used_q <= used_d;
            if (wr_acc_c) begin
                wptr <= wptr + ADDR_WIDTH'(1);
            end
            if (ram_rd_c) begin
                rptr <= rptr + ADDR_WIDTH'(1);
            end
        end
    end

    generate
        if (fifo_is_fwft(MODE)) begin : g_fwft
            logic                  s1_valid;
            logic                  head_valid;
            logic [DATA_WIDTH-1:0] head;
            logic [CW-1:0]         ram_cnt_c;
            logic                  head_load_c;
            logic                  fetch_c;

            // Words still sitting in RAM = total held minus the two prefetch stages.
            assign ram_cnt_c   = used_q - CW'(s1_valid) - CW'(head_valid);
            assign head_load_c = s1_valid & (~head_valid | rd_acc_c);
            assign fetch_c     = ~flush & (ram_cnt_c != '0) & (~s1_valid | head_load_c);

            assign ram_rd_c = fetch_c;
            assign empty    = ~head_valid;
            assign rdata    = head;

            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    s1_valid   <= 1'b0;
                    head_valid <= 1'b0;
                    head       <= '0;
                end else if (flush) begin
                    s1_valid   <= 1'b0;
                    head_valid <= 1'b0;
                end else begin
                    if (fetch_c) begin
                        s1_valid <= 1'b1;
                    end else if (head_load_c) begin
                        s1_valid <= 1'b0;
                    end
                    if (head_load_c) begin
                        head_valid <= 1'b1;
                        head       <= ram_q;
                    end else if (rd_acc_c) begin
                        head_valid <= 1'b0;
                    end
                end
            end
        end else begin : g_std
            // RAM output register is the read data; it only moves on an accepted read.
            assign ram_rd_c = rd_acc_c;
            assign empty    = (used_q == '0);
            assign rdata    = ram_q;
        end
    endgenerate

`ifdef FIFO_SYNC_ERRFLAG_EN
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we && full) begin
                overflow <= 1'b1;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync: one FWFT instance and one standard-read instance.
module tb_fifo_sync;
    import fifo_pkg::*;

`ifdef FIFO_SYNC_ERRFLAG_EN
    localparam bit ERRF = 1'b1;
`else
    localparam bit ERRF = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetb = 1'b0;

    logic       f_flush = 0, f_we = 0, f_re = 0;
    logic [7:0] f_wdata = 0, f_rdata;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] f_used, f_free;

    logic       s_flush = 0, s_we = 0, s_re = 0;
    logic [7:0] s_wdata = 0, s_rdata;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [4:0] s_used, s_free;

    logic [4:0] afull_th  = 5'd12;
    logic [4:0] aempty_th = 5'd2;

    logic [7:0] f_q[$];
    logic [7:0] s_q[$];
    logic       s_pend = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    fifo_sync #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .MODE(FIFO_MODE_FWFT)) u_fwft (
        .clk(clk), .resetb(resetb), .flush(f_flush), .we(f_we), .wdata(f_wdata),
        .re(f_re), .rdata(f_rdata), .full(f_full), .empty(f_empty), .used(f_used),
        .free(f_free), .afull_thresh(afull_th), .aempty_thresh(aempty_th),
        .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
    );

    fifo_sync #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .MODE(FIFO_MODE_STD)) u_std (
        .clk(clk), .resetb(resetb), .flush(s_flush), .we(s_we), .wdata(s_wdata),
        .re(s_re), .rdata(s_rdata), .full(s_full), .empty(s_empty), .used(s_used),
        .free(s_free), .afull_thresh(afull_th), .aempty_thresh(aempty_th),
        .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: FWFT head is checked when it is popped; standard data one cycle after the read.
    always @(negedge clk) begin
        if (resetb) begin
            if (f_re && !f_empty) begin
                if (f_q.size() == 0) chk("fwft_pop_unexpected", 32'(f_rdata), 32'hFFFF);
                else chk("fwft_pop_data", 32'(f_rdata), 32'(f_q.pop_front()));
            end
            if (s_pend) begin
                if (s_q.size() == 0) chk("std_pop_unexpected", 32'(s_rdata), 32'hFFFF);
                else chk("std_pop_data", 32'(s_rdata), 32'(s_q.pop_front()));
            end
            s_pend = s_re && !s_empty && !s_flush;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset state, checked while reset is still asserted.
        repeat (2) @(posedge clk);
        #3;
        chk("rst_used", 32'(f_used), 0);
        chk("rst_free", 32'(f_free), 16);
        chk("rst_full", 32'(f_full), 0);
        chk("rst_empty", 32'(f_empty), 1);
        chk("rst_rdata", 32'(f_rdata), 0);
        chk("rst_ovf", 32'(f_ovf), 0);
        chk("rst_unf", 32'(f_unf), 0);
        chk("rst_std_empty", 32'(s_empty), 1);
        resetb = 1'b1;
        step();

        // Single write into empty FWFT FIFO: used at N, data visible after N+2.
        f_we = 1; f_wdata = 8'h5A; f_q.push_back(8'h5A);
        step();
        f_we = 0;
        chk("lat_used_n", 32'(f_used), 1);
        chk("lat_empty_n", 32'(f_empty), 1);
        step();
        chk("lat_empty_n1", 32'(f_empty), 1);
        step();
        chk("lat_empty_n2", 32'(f_empty), 0);
        chk("lat_rdata_n2", 32'(f_rdata), 32'h5A);
        f_re = 1;
        step();
        f_re = 0;
        chk("lat_empty_after_pop", 32'(f_empty), 1);
        chk("lat_used_after_pop", 32'(f_used), 0);

        // Fill 0x01..0x10, watching the almost_full / almost_empty thresholds.
        for (int i = 1; i <= 16; i++) begin
            f_we = 1; f_wdata = 8'(i); f_q.push_back(8'(i));
            step();
            chk("fill_used", 32'(f_used), 32'(i));
            chk("fill_afull", 32'(f_af), (i >= 12) ? 1 : 0);
            chk("fill_aempty", 32'(f_ae), (i <= 2) ? 1 : 0);
        end
        chk("full_flag", 32'(f_full), 1);
        chk("full_free", 32'(f_free), 0);
        f_wdata = 8'hAA;
        step();
        chk("ovf_used", 32'(f_used), 16);
        chk("ovf_flag", 32'(f_ovf), 32'(ERRF));

        // Full with simultaneous write/read: write dropped, read taken.
        f_wdata = 8'hBB; f_re = 1;
        step();
        f_we = 0;
        chk("wr_rd_full_used", 32'(f_used), 15);
        chk("wr_rd_full_full", 32'(f_full), 0);
        chk("wr_rd_full_ovf", 32'(f_ovf), 32'(ERRF));

        // Drain back-to-back: one pop per cycle with no bubble.
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("drain_used", 32'(f_used), 32'(15 - k));
            chk("drain_aempty", 32'(f_ae), (15 - k <= 2) ? 1 : 0);
            chk("drain_empty", 32'(f_empty), (k == 15) ? 1 : 0);
        end
        step();
        f_re = 0;
        chk("unf_flag", 32'(f_unf), 32'(ERRF));
        chk("unf_used", 32'(f_used), 0);

        // Fill 9, then flush together with a write.
        for (int i = 0; i < 9; i++) begin
            f_we = 1; f_wdata = 8'(8'h40 + i);
            step();
        end
        f_we = 1; f_wdata = 8'hEE; f_flush = 1;
        step();
        f_we = 0; f_flush = 0;
        chk("flush_used", 32'(f_used), 0);
        chk("flush_empty", 32'(f_empty), 1);
        chk("flush_full", 32'(f_full), 0);
        chk("flush_free", 32'(f_free), 16);
        chk("flush_ovf", 32'(f_ovf), 0);
        chk("flush_unf", 32'(f_unf), 0);
        step();
        chk("flush_still_empty", 32'(f_empty), 1);

        // 20 writes with concurrent reads so both pointers wrap.
        for (int i = 0; i < 20; i++) begin
            f_we = 1; f_wdata = 8'(8'h60 + i); f_q.push_back(8'(8'h60 + i));
            f_re = !f_empty;
            step();
        end
        f_we = 0;
        for (int i = 0; i < 12; i++) begin
            f_re = !f_empty;
            step();
        end
        f_re = 0;
        step();
        chk("wrap_used_end", 32'(f_used), 0);
        chk("wrap_queue_left", 32'(f_q.size()), 0);

        // Standard-read instance: 3 words, a single read, then hold behaviour.
        s_we = 1; s_wdata = 8'h11; s_q.push_back(8'h11); step();
        s_wdata = 8'h22; s_q.push_back(8'h22); step();
        s_wdata = 8'h33; s_q.push_back(8'h33); step();
        s_we = 0;
        chk("std_used3", 32'(s_used), 3);
        chk("std_empty3", 32'(s_empty), 0);
        s_re = 1;
        step();
        s_re = 0;
        chk("std_rdata_first", 32'(s_rdata), 32'h11);
        chk("std_used2", 32'(s_used), 2);
        step();
        chk("std_rdata_hold", 32'(s_rdata), 32'h11);
        s_re = 1;
        step();
        step();
        s_re = 0;
        step();
        chk("std_rdata_last", 32'(s_rdata), 32'h33);
        chk("std_empty_end", 32'(s_empty), 1);
        s_re = 1;
        step();
        s_re = 0;
        step();
        chk("std_unf_rdata", 32'(s_rdata), 32'h33);
        chk("std_unf_used", 32'(s_used), 0);
        chk("std_unf_flag", 32'(s_unf), 32'(ERRF));
        chk("std_queue_left", 32'(s_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
